rsa16: RTL and testbench

- 16-bit modular exponentiation engine: o_result = i_base^i_exp mod i_N.
- Serves as the compute core of the RSA16 peripheral; the bus wrapper loads operands, pulses start and polls o_end.
- Right-to-left binary square-and-multiply over all 16 exponent bits.
- Modular products use an iterative interleaved shift-add multiplier, giving fixed, data-independent latency.

---
 rtl/rsa16_pkg.sv | 36 +++
 rtl/rsa16_modmul.sv | 58 +++++
 rtl/rsa16.sv | 154 +++++++++++++++
 tb/tb_rsa16.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rsa16_pkg.sv
// Shared types, constants and the modular-multiply iteration step for the
// rsa16 modular exponentiation engine.
package rsa16_pkg;

  localparam int W         = 16;
  localparam int DW        = W + 2;   // modmul datapath width, holds values < 3N
  localparam int MM_ITERS  = W;       // shift-add iterations per modular multiply
  localparam int MM_CYCLES = MM_ITERS + 1;
  localparam int LATENCY   = MM_CYCLES + W * MM_CYCLES;
  localparam int PHASES    = W;       // one LOOP phase per exponent bit

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    LOOP = 2'd2,
    DONE = 2'd3
  } state_t;

  // One interleaved step: P = 2P + a*B, then up to two subtractions of N.
  // With P < N and B < N the sum is below 3N, so two corrections suffice.
  function automatic logic [DW-1:0] mm_step(
    input logic [DW-1:0] p,
    input logic [W-1:0]  b,
    input logic [W-1:0]  n,
    input logic          a_bit
  );
    logic [DW-1:0] t;
    logic [DW-1:0] n_ext;
    n_ext = {2'b00, n};
    t = {p[DW-2:0], 1'b0} + (a_bit ? {2'b00, b} : {DW{1'b0}});
    if (t >= n_ext) t = t - n_ext;
    if (t >= n_ext) t = t - n_ext;
    return t;
  endfunction

endpackage

// File: rtl/rsa16_modmul.sv
// Iterative modular multiplier: P = A*B mod N in one launch cycle plus
// MM_ITERS shift-add iterations, consuming A from its MSB downwards.
// A launch always wins, even over an operation still in progress.
module rsa16_modmul
  import rsa16_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] n_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] p_o
);

  logic [W-1:0]  a_q, b_q, n_q;
  logic [DW-1:0] p_q, p_d;
  logic [4:0]    cnt_q;
  logic          run_q;
  logic          iter_last;

  assign iter_last = (cnt_q == 5'(MM_ITERS));

  // Next partial product for the current multiplier bit.
  always_comb begin
    p_d = mm_step(p_q, b_q, n_q, a_q[W-1]);
  end

  // Launch loads operands and clears the accumulator; otherwise iterate until done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      n_q   <= n_i;
      p_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q && !iter_last) begin
      p_q   <= p_d;
      a_q   <= {a_q[W-2:0], 1'b0};
      cnt_q <= cnt_q + 5'd1;
    end
  end

  assign busy_o = run_q && !iter_last;
  assign done_o = run_q && iter_last;
  assign p_o    = p_q[W-1:0];

endmodule

// File: rtl/rsa16.sv
// 16-bit modular exponentiation (base^exp mod N), right-to-left binary
// square-and-multiply over all exponent bits with fixed latency.
// The square unit first reduces the base (base*1 mod N) during INIT, then
// squares once per LOOP phase; the multiply unit runs every phase and its
// product is kept only when the current exponent bit is set.
// Handshake: a start is accepted on a rising edge with i_start=1 in IDLE or
// DONE; o_end rises LATENCY edges later with o_result valid, and both hold
// until the next accepted start or reset.
module rsa16
  import rsa16_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_base,
  input  logic [W-1:0] i_exp,
  input  logic [W-1:0] i_N,
  output logic [W-1:0] o_result,
  output logic         o_end
);

  state_t       state_q;
  logic [W-1:0] exp_q, n_q;
  logic [W-1:0] base_r_q, res_r_q;
  logic [3:0]   phase_q;
  logic [W-1:0] result_q;
  logic         end_q;

  logic         accept;
  logic [W-1:0] res_init, res_next, base_next;
  logic [W-1:0] mm_n;

  logic         sq_start, sq_busy, sq_done;
  logic [W-1:0] sq_a, sq_b, sq_p;
  logic         mul_start, mul_busy, mul_done;
  logic [W-1:0] mul_a, mul_b, mul_p;
  logic         units_idle, phase_end;

  assign units_idle = !sq_busy && !mul_busy;
  assign phase_end  = sq_done && mul_done && units_idle;

  // Launch control and operand muxing for both multiply units.
  always_comb begin
    accept    = i_start && ((state_q == IDLE) || (state_q == DONE));
    res_init  = (n_q > 16'd1) ? 16'd1 : 16'd0;
    res_next  = exp_q[phase_q] ? mul_p : res_r_q;
    base_next = sq_p;
    mm_n      = accept ? i_N : n_q;
    sq_start  = 1'b0;
    sq_a      = base_r_q;
    sq_b      = base_r_q;
    mul_start = 1'b0;
    mul_a     = res_r_q;
    mul_b     = base_r_q;
    if (accept) begin
      sq_start = 1'b1;
      sq_a     = i_base;
      sq_b     = 16'd1;
    end else if ((state_q == INIT) && sq_done && units_idle) begin
      sq_start  = 1'b1;
      sq_a      = sq_p;
      sq_b      = sq_p;
      mul_start = 1'b1;
      mul_a     = res_init;
      mul_b     = sq_p;
    end else if ((state_q == LOOP) && phase_end && (phase_q != 4'(PHASES - 1))) begin
      sq_start  = 1'b1;
      sq_a      = base_next;
      sq_b      = base_next;
      mul_start = 1'b1;
      mul_a     = res_next;
      mul_b     = base_next;
    end
  end

  rsa16_modmul u_sq (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .start_i (sq_start),
    .a_i     (sq_a),
    .b_i     (sq_b),
    .n_i     (mm_n),
    .busy_o  (sq_busy),
    .done_o  (sq_done),
    .p_o     (sq_p)
  );

  rsa16_modmul u_mul (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .start_i (mul_start),
    .a_i     (mul_a),
    .b_i     (mul_b),
    .n_i     (mm_n),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );

  // Sequencer: operand capture, per-phase register update and result latch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      exp_q    <= '0;
      n_q      <= '0;
      base_r_q <= '0;
      res_r_q  <= '0;
      phase_q  <= '0;
      result_q <= '0;
      end_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            exp_q    <= i_exp;
            n_q      <= i_N;
            base_r_q <= '0;
            res_r_q  <= '0;
            phase_q  <= '0;
            end_q    <= 1'b0;
            state_q  <= INIT;
          end
        end
        INIT: begin
          if (sq_done && units_idle) begin
            base_r_q <= sq_p;
            res_r_q  <= res_init;
            phase_q  <= '0;
            state_q  <= LOOP;
          end
        end
        LOOP: begin
          if (phase_end) begin
            base_r_q <= base_next;
            res_r_q  <= res_next;
            if (phase_q == 4'(PHASES - 1)) begin
              // A zero modulus has no meaningful residue; report 0.
              result_q <= (n_q == 16'd0) ? 16'd0 : res_next;
              end_q    <= 1'b1;
              state_q  <= DONE;
            end else begin
              phase_q <= phase_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_result = result_q;
  assign o_end    = end_q;

endmodule

// File: tb/tb_rsa16.sv
// Self-checking bench for rsa16: directed vectors with hand-computed
// results, boundary operands, busy/reset behaviour and a random sweep
// against a software modpow reference.
module tb_rsa16;

  localparam int LAT = 289;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base = '0, expo = '0, modn = '0;
  logic [15:0] result;
  logic        done;

  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] exp_q[$];

  rsa16 dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_base   (base),
    .i_exp    (expo),
    .i_N      (modn),
    .o_result (result),
    .o_end    (done)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic logic [15:0] modpow(input logic [15:0] b, input logic [15:0] e,
                                         input logic [15:0] m);
    longint r, x, mm;
    if (m == 16'd0) return 16'd0;
    mm = longint'(m);
    r  = 1 % mm;
    x  = longint'(b) % mm;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return 16'(r);
  endfunction

  // Present operands for one rising edge, then scramble them.
  task automatic start_op(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m);
    @(negedge clk);
    base  = b;
    expo  = e;
    modn  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    base  = 16'($urandom);
    expo  = 16'($urandom);
    modn  = 16'($urandom);
    check("start_clr", {31'd0, done}, 32'd0);
  endtask

  // Count rising edges since the start edge until o_end is seen.
  task automatic wait_done(input string tag, input int already);
    int edges;
    edges = already;
    while (!done && edges < LAT + 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_lat"}, 32'(edges), 32'(LAT));
  endtask

  task automatic run(input string tag, input logic [15:0] b, input logic [15:0] e,
                     input logic [15:0] m, input logic [15:0] want);
    exp_q.push_back(want);
    start_op(b, e, m);
    wait_done(tag, 0);
    check(tag, {16'd0, result}, {16'd0, exp_q.pop_front()});
  endtask

  initial begin
    logic [15:0] rb, re, rn;

    // reset asserted between edges: outputs cleared without a clock edge
    #3 rst = 1'b1;
    #1;
    check("rst_end", {31'd0, done}, 32'd0);
    check("rst_res", {16'd0, result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("pow_4_13_497", 16'd4, 16'd13, 16'd497, 16'd445);
    repeat (10) @(posedge clk);
    #1;
    check("hold_end", {31'd0, done}, 32'd1);
    check("hold_res", {16'd0, result}, 32'd445);

    // mid-clock reset after a completed result
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst2_end", {31'd0, done}, 32'd0);
    check("rst2_res", {16'd0, result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("idle_end", {31'd0, done}, 32'd0);

    // back-to-back restart from DONE (start_op checks o_end drops)
    run("pow_2_10_1000", 16'd2, 16'd10, 16'd1000, 16'd24);
    run("exp0", 16'd3, 16'd0, 16'd7, 16'd1);

    // boundary operands
    run("n_one", 16'd1234, 16'd5, 16'd1, 16'd0);
    run("base0", 16'd0, 16'd7, 16'd11, 16'd0);
    run("base_ge_n", 16'd20, 16'd1, 16'd7, 16'd6);
    run("n_zero", 16'd5, 16'd3, 16'd0, 16'd0);

    // start pulse while busy must be ignored
    exp_q.push_back(16'd24);
    start_op(16'd2, 16'd10, 16'd1000);
    repeat (100) @(posedge clk);
    @(negedge clk);
    base  = 16'd7;
    expo  = 16'd3;
    modn  = 16'd11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy", 101);
    check("busy", {16'd0, result}, {16'd0, exp_q.pop_front()});

    // reset mid-LOOP, then a fresh computation
    start_op(16'd9, 16'd65535, 16'd1001);
    repeat (150) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst3_end", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run("after_rst", 16'd4, 16'd13, 16'd497, 16'd445);

    // random sweep against the software reference
    for (int i = 0; i < 200; i++) begin
      rb = 16'($urandom);
      re = 16'($urandom);
      rn = 16'($urandom_range(65535, 2));
      run("rand", rb, re, rn, modpow(rb, re, rn));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
